sisc_ctrl_mc: RTL and testbench



---
 rtl/sisc_pkg.sv | 35 +++
 rtl/sisc_ctrl_mc_if.sv | 37 +++
 rtl/sisc_mem_wait.sv | 46 ++++
 rtl/sisc_ctrl_mc.sv | 133 +++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC multi-cycle controller: opcodes, FSM states,
// ALU operation encodings and the immediate-addressing mode value.
package sisc_pkg;

  localparam int unsigned OpNoop = 0;
  localparam int unsigned OpLod  = 1;
  localparam int unsigned OpStr  = 2;
  localparam int unsigned OpSwp  = 3;
  localparam int unsigned OpBra  = 4;
  localparam int unsigned OpBrr  = 5;
  localparam int unsigned OpBne  = 6;
  localparam int unsigned OpBnr  = 7;
  localparam int unsigned OpAlu  = 8;
  localparam int unsigned OpHlt  = 15;

  localparam int unsigned ImmMm = 8;

  // Bit 0 marks an ALU instruction, bit 1 selects the immediate operand.
  localparam logic [1:0] AluNone = 2'b00;
  localparam logic [1:0] AluReg  = 2'b01;
  localparam logic [1:0] AluAddr = 2'b10;
  localparam logic [1:0] AluImm  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StWb2,
    StHalt
  } state_e;

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// Bundle between the controller and the datapath: instruction fields, status
// and memory handshake in, control strobes and the retired counter out.
interface sisc_ctrl_mc_if #(
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned MM_W     = 4,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned CNT_W    = 16
);
  logic [OPC_W-1:0]    opcode;
  logic [MM_W-1:0]     mm;
  logic [MM_W-1:0]     stat;
  logic                mem_ack;
  logic                ir_load;
  logic                pc_write;
  logic                pc_sel;
  logic                br_sel;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_rd;
  logic                mem_wr;
  logic                rf_we;
  logic                wb_sel;
  logic                rd_sel;
  logic                halted;
  logic [CNT_W-1:0]    instr_cnt;

  modport master (
    input  opcode, mm, stat, mem_ack,
    output ir_load, pc_write, pc_sel, br_sel, alu_op, mem_rd, mem_wr,
           rf_we, wb_sel, rd_sel, halted, instr_cnt
  );

  modport slave (
    output opcode, mm, stat, mem_ack,
    input  ir_load, pc_write, pc_sel, br_sel, alu_op, mem_rd, mem_wr,
           rf_we, wb_sel, rd_sel, halted, instr_cnt
  );
endinterface

// File: rtl/sisc_mem_wait.sv
// Memory-access completion: fixed-latency down-counter, or pass-through of the
// memory ack when MEM_LAT is 0.
module sisc_mem_wait #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic done
);

  if (MEM_LAT == 0) begin : g_ack
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign done = start & ack;
  end else begin : g_cnt
    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0] Preload = CntW'(MEM_LAT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            unused_ack;
    assign unused_ack = ack;

    // Reloaded every cycle outside MEM so each access starts from a full count.
    always_comb begin
      cnt_d = cnt_q;
      if (!start) begin
        cnt_d = Preload;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign done = start && (cnt_q == '0);
  end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// SISC multi-cycle control unit: Moore FSM decoding the latched instruction,
// with memory wait, two-cycle SWP writeback, sticky halt and retired counter.
module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned MM_W     = 4,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned IMM_MM   = ImmMm,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_ctrl_mc_if.master bus
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  logic [MM_W-1:0]  mm_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_lod, is_str, is_swp, is_alu, is_bra, is_brr, is_bne, is_bnr;
  logic             hit, mem_done, wait_done, retire;

  assign is_lod = (opc_q == OPC_W'(OpLod));
  assign is_str = (opc_q == OPC_W'(OpStr));
  assign is_swp = (opc_q == OPC_W'(OpSwp));
  assign is_bra = (opc_q == OPC_W'(OpBra));
  assign is_brr = (opc_q == OPC_W'(OpBrr));
  assign is_bne = (opc_q == OPC_W'(OpBne));
  assign is_bnr = (opc_q == OPC_W'(OpBnr));
  assign is_alu = (opc_q == OPC_W'(OpAlu));
  assign hit    = |(bus.stat & mm_q);

  sisc_mem_wait #(
    .MEM_LAT (MEM_LAT)
  ) u_mem_wait (
    .clk   (clk),
    .rst   (rst_f),
    .start ((state_q == StMem) && (is_lod || is_str)),
    .ack   (bus.mem_ack),
    .done  (wait_done)
  );

  // Non-memory opcodes pass through MEM in a single cycle.
  assign mem_done = (is_lod || is_str) ? wait_done : 1'b1;
  assign retire   = ((state_q == StWb) && !is_swp) || (state_q == StWb2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = StFetch;
      StFetch:   state_d = StDecode;
      StDecode:  state_d = (bus.opcode == OPC_W'(OpHlt)) ? StHalt : StExecute;
      StExecute: state_d = StMem;
      StMem:     if (mem_done) state_d = StWb;
      StWb:      state_d = is_swp ? StWb2 : StFetch;
      StWb2:     state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q <= StIdle;
      opc_q   <= '0;
      mm_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opc_q <= bus.opcode;
        mm_q  <= bus.mm;
      end
      if (retire && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.ir_load  = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.alu_op   = ALU_OP_W'(AluNone);
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.rd_sel   = 1'b0;
    bus.halted   = (state_q == StHalt);

    if ((state_q == StExecute) || (state_q == StMem) || (state_q == StWb)) begin
      if (is_alu) begin
        bus.alu_op = ALU_OP_W'((mm_q == MM_W'(IMM_MM)) ? AluImm : AluReg);
      end else if (is_lod || is_str) begin
        bus.alu_op = ALU_OP_W'(AluAddr);
      end
    end

    unique case (state_q)
      StFetch: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      StExecute: begin
        if (((is_bra || is_brr) && hit) || ((is_bne || is_bnr) && !hit)) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = 1'b1;
        end
        bus.br_sel = is_brr || is_bnr;
      end
      StMem: begin
        bus.mem_rd = is_lod;
        bus.mem_wr = is_str;
      end
      StWb: begin
        bus.rf_we  = is_alu || is_lod || is_swp;
        bus.wb_sel = is_lod;
      end
      StWb2: begin
        bus.rf_we  = 1'b1;
        bus.rd_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: one ack-driven instance (MEM_LAT=0) and one
// fixed-latency instance (MEM_LAT=4), checked cycle by cycle.
module tb_sisc_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cnt_x, cnt_y, at;

  always #5 clk = ~clk;

  sisc_ctrl_mc_if #(.OPC_W(4), .MM_W(4), .ALU_OP_W(2), .CNT_W(16)) bus_a ();
  sisc_ctrl_mc_if #(.OPC_W(4), .MM_W(4), .ALU_OP_W(2), .CNT_W(16)) bus_b ();

  sisc_ctrl_mc #(.MEM_LAT(0)) u_a (.clk(clk), .rst_f(rst_a), .bus(bus_a.master));
  sisc_ctrl_mc #(.MEM_LAT(4)) u_b (.clk(clk), .rst_f(rst_b), .bus(bus_b.master));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.opcode = 4'd0; bus_a.mm = 4'd0; bus_a.stat = 4'd0; bus_a.mem_ack = 1'b0;
    bus_b.opcode = 4'd0; bus_b.mm = 4'd0; bus_b.stat = 4'd0; bus_b.mem_ack = 1'b0;
    #12;
    check_val("rst_ir_load", 32'(bus_a.ir_load), 0);
    check_val("rst_pc_write", 32'(bus_a.pc_write), 0);
    check_val("rst_halted", 32'(bus_a.halted), 0);
    check_val("rst_instr_cnt", 32'(bus_a.instr_cnt), 0);

    // ALU_OP immediate
    @(posedge clk); #1 rst_a = 1'b0;
    bus_a.opcode = 4'd8; bus_a.mm = 4'd8;
    check_val("idle_ir_load", 32'(bus_a.ir_load), 0);
    step();
    check_val("alu_c1_ir_load", 32'(bus_a.ir_load), 1);
    check_val("alu_c1_pc_write", 32'(bus_a.pc_write), 1);
    step();
    check_val("alu_c2_alu_op", 32'(bus_a.alu_op), 0);
    step();
    check_val("alu_c3_alu_op", 32'(bus_a.alu_op), 3);
    step();
    check_val("alu_c4_alu_op", 32'(bus_a.alu_op), 3);
    step();
    check_val("alu_c5_alu_op", 32'(bus_a.alu_op), 3);
    check_val("alu_c5_rf_we", 32'(bus_a.rf_we), 1);
    check_val("alu_c5_wb_sel", 32'(bus_a.wb_sel), 0);
    step();
    check_val("alu_cnt", 32'(bus_a.instr_cnt), 1);
    check_val("alu_next_fetch", 32'(bus_a.ir_load), 1);

    // BRR taken
    bus_a.opcode = 4'd5; bus_a.mm = 4'b0010;
    step();
    bus_a.stat = 4'b0010;
    step();
    check_val("brr_t_pc_write", 32'(bus_a.pc_write), 1);
    check_val("brr_t_pc_sel", 32'(bus_a.pc_sel), 1);
    check_val("brr_t_br_sel", 32'(bus_a.br_sel), 1);
    step(); step(); step();
    check_val("brr_t_cnt", 32'(bus_a.instr_cnt), 2);

    // BRR not taken
    step();
    bus_a.stat = 4'b0100;
    step();
    check_val("brr_nt_pc_write", 32'(bus_a.pc_write), 0);
    check_val("brr_nt_pc_sel", 32'(bus_a.pc_sel), 0);
    step(); step(); step();
    check_val("brr_nt_cnt", 32'(bus_a.instr_cnt), 3);

    // BNE taken when no flag matches
    bus_a.opcode = 4'd6; bus_a.mm = 4'b0001; bus_a.stat = 4'b0000;
    step(); step();
    check_val("bne_pc_write", 32'(bus_a.pc_write), 1);
    check_val("bne_pc_sel", 32'(bus_a.pc_sel), 1);
    check_val("bne_br_sel", 32'(bus_a.br_sel), 0);
    step(); step(); step();
    check_val("bne_cnt", 32'(bus_a.instr_cnt), 4);

    // Unknown opcode acts as NOOP
    bus_a.opcode = 4'd9; bus_a.mm = 4'd8;
    step(); step();
    check_val("unk_alu_op", 32'(bus_a.alu_op), 0);
    check_val("unk_pc_write", 32'(bus_a.pc_write), 0);
    step(); step();
    check_val("unk_rf_we", 32'(bus_a.rf_we), 0);
    step();
    check_val("unk_cnt", 32'(bus_a.instr_cnt), 5);

    // LOD with ack; an early ack during EXECUTE must not complete MEM
    bus_a.opcode = 4'd1; bus_a.mm = 4'd0;
    step();
    bus_a.mem_ack = 1'b1;
    step();
    check_val("lod_alu_op", 32'(bus_a.alu_op), 2);
    cnt_x = 0;
    step();
    bus_a.mem_ack = 1'b0;
    if (bus_a.mem_rd) cnt_x++;
    step();
    if (bus_a.mem_rd) cnt_x++;
    step();
    if (bus_a.mem_rd) cnt_x++;
    bus_a.mem_ack = 1'b1;
    step();
    bus_a.mem_ack = 1'b0;
    check_val("lod_rd_cycles", cnt_x, 3);
    check_val("lod_wb_mem_rd", 32'(bus_a.mem_rd), 0);
    check_val("lod_wb_rf_we", 32'(bus_a.rf_we), 1);
    check_val("lod_wb_wb_sel", 32'(bus_a.wb_sel), 1);
    step();
    check_val("lod_cnt", 32'(bus_a.instr_cnt), 6);

    // SWP: WB then WB2, next FETCH in cycle 7
    bus_a.opcode = 4'd3;
    step(); step(); step(); step();
    check_val("swp_wb_rf_we", 32'(bus_a.rf_we), 1);
    check_val("swp_wb_rd_sel", 32'(bus_a.rd_sel), 0);
    step();
    check_val("swp_wb2_rf_we", 32'(bus_a.rf_we), 1);
    check_val("swp_wb2_rd_sel", 32'(bus_a.rd_sel), 1);
    check_val("swp_wb2_ir_load", 32'(bus_a.ir_load), 0);
    step();
    check_val("swp_c7_ir_load", 32'(bus_a.ir_load), 1);
    check_val("swp_cnt", 32'(bus_a.instr_cnt), 7);

    // HLT is sticky until reset
    bus_a.opcode = 4'd15;
    step();
    check_val("hlt_dec_halted", 32'(bus_a.halted), 0);
    step();
    check_val("hlt_halted", 32'(bus_a.halted), 1);
    cnt_x = 0;
    cnt_y = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_a.ir_load) cnt_x++;
      if (!bus_a.halted) cnt_y++;
    end
    check_val("hlt_ir_loads", cnt_x, 0);
    check_val("hlt_not_halted", cnt_y, 0);
    check_val("hlt_cnt", 32'(bus_a.instr_cnt), 7);
    rst_a = 1'b1;
    #1;
    check_val("hlt_rst_halted", 32'(bus_a.halted), 0);
    check_val("hlt_rst_cnt", 32'(bus_a.instr_cnt), 0);
    @(posedge clk); #1 rst_a = 1'b0;
    bus_a.opcode = 4'd0;
    check_val("hlt_idle_ir_load", 32'(bus_a.ir_load), 0);
    step();
    check_val("hlt_refetch", 32'(bus_a.ir_load), 1);

    // STR with four-cycle memory latency
    @(posedge clk); #1 rst_b = 1'b0;
    bus_b.opcode = 4'd2;
    step(); step(); step();
    check_val("str_alu_op", 32'(bus_b.alu_op), 2);
    cnt_x = 0;
    at = 99;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_b.mem_wr) cnt_x++;
      if (bus_b.ir_load) begin
        at = i;
        break;
      end
    end
    check_val("str_wr_cycles", cnt_x, 4);
    check_val("str_next_fetch", at, 5);
    check_val("str_cnt", 32'(bus_b.instr_cnt), 1);

    // Reset mid-MEM drops the strobe at once and clears the wait counter
    @(posedge clk); #1 rst_b = 1'b1;
    @(posedge clk); #1 rst_b = 1'b0;
    step(); step(); step(); step();
    check_val("strr_m1_mem_wr", 32'(bus_b.mem_wr), 1);
    step();
    check_val("strr_m2_mem_wr", 32'(bus_b.mem_wr), 1);
    rst_b = 1'b1;
    #1;
    check_val("strr_rst_mem_wr", 32'(bus_b.mem_wr), 0);
    check_val("strr_rst_cnt", 32'(bus_b.instr_cnt), 0);
    @(posedge clk); #1 rst_b = 1'b0;
    step();
    check_val("strr_refetch", 32'(bus_b.ir_load), 1);
    step(); step();
    cnt_x = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_b.mem_wr) cnt_x++;
      if (bus_b.ir_load) break;
    end
    check_val("strr_wr_cycles", cnt_x, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
